// File: rtl/store_sink_pkg.sv
// Shared types and constants for the write-back store sink.
//   sink_state_t        : sink FSM state (RUN accepts stores, DONE ignores them)
//   TOHOST_ADDR_DEFAULT : default byte address of the end-of-test mailbox
//   store_entry_t       : one buffered store {addr, wdata}
package store_sink_pkg;

  typedef enum logic [0:0] {
    RUN,
    DONE
  } sink_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FF0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
  } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Small synchronous FIFO of store entries.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : enqueue request and payload (ignored while full)
//   pop          : dequeue request (ignored while empty)
//   full, empty  : occupancy status, derived from registered pointers only
//   head         : oldest entry; all-zero while empty
module store_fifo
  import store_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  store_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output store_entry_t head
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  store_entry_t    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            do_push, do_pop;

  // Index bits equal: wrap bit tells full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                 (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[IdxW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr_q[IdxW-1:0]];

endmodule

// File: rtl/mem_store_sink.sv
// Receiver for the write-back store port. Classifies each store, buffers normal stores
// in a FIFO drained to the data RAM over valid/ready, and decodes the TOHOST mailbox
// that ends the test.
// Optional feature macro: STORE_SINK_COUNT_EN (enables the saturating store counter;
// when undefined o_store_count is tied to zero).
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   i_MemWrite, i_mem_addr, i_mem_wdata : store strobe, byte address, data
//   o_full                 : FIFO full, datapath stalls stores
//   o_ram_valid, i_ram_ready, o_ram_addr, o_ram_wdata : RAM drain handshake and head entry
//   o_done, o_done_code    : sticky TOHOST-written flag and its data
//   o_misaligned, o_overflow : sticky error flags
//   o_store_count          : saturating count of enqueued stores
module mem_store_sink
  import store_sink_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_MemWrite,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  output logic             o_full,
  output logic             o_ram_valid,
  input  logic             i_ram_ready,
  output logic [31:0]      o_ram_addr,
  output logic [31:0]      o_ram_wdata,
  output logic             o_done,
  output logic [31:0]      o_done_code,
  output logic             o_misaligned,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_store_count
);

  sink_state_t  state_q, state_d;
  logic [31:0]  done_code_q, done_code_d;
  logic         misaligned_q, misaligned_d;
  logic         overflow_q, overflow_d;
  logic         push;
  logic         fifo_full, fifo_empty;
  store_entry_t push_data, head;

  assign push_data = '{addr: i_mem_addr, wdata: i_mem_wdata};

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (i_ram_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Classifier and FSM next state. Full is the registered flag, so a pop in the same
  // cycle does not make room for the incoming store.
  always_comb begin
    state_d      = state_q;
    done_code_d  = done_code_q;
    misaligned_d = misaligned_q;
    overflow_d   = overflow_q;
    push         = 1'b0;
    if (state_q == RUN && i_MemWrite) begin
      if (i_mem_addr[1:0] != 2'b00) begin
        misaligned_d = 1'b1;
      end else if (i_mem_addr == TOHOST_ADDR) begin
        done_code_d = i_mem_wdata;
        state_d     = DONE;
      end else if (fifo_full) begin
        overflow_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      done_code_q  <= '0;
      misaligned_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_code_q  <= done_code_d;
      misaligned_q <= misaligned_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef STORE_SINK_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign o_store_count = count_q;
`else
  assign o_store_count = '0;
`endif

  assign o_full       = fifo_full;
  assign o_ram_valid  = !fifo_empty;
  assign o_ram_addr   = head.addr;
  assign o_ram_wdata  = head.wdata;
  assign o_done       = (state_q == DONE);
  assign o_done_code  = done_code_q;
  assign o_misaligned = misaligned_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_mem_store_sink.sv
// Scoreboard bench for mem_store_sink: stores are classified by a bench model when
// driven, accepted entries queued, and compared as the RAM side pops them.
module tb_mem_store_sink;
  import store_sink_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_MemWrite;
  logic [31:0]      i_mem_addr;
  logic [31:0]      i_mem_wdata;
  logic             o_full;
  logic             o_ram_valid;
  logic             i_ram_ready;
  logic [31:0]      o_ram_addr;
  logic [31:0]      o_ram_wdata;
  logic             o_done;
  logic [31:0]      o_done_code;
  logic             o_misaligned;
  logic             o_overflow;
  logic [CNT_W-1:0] o_store_count;

  always #5 clk = ~clk;

  mem_store_sink #(
    .DEPTH       (DEPTH),
    .TOHOST_ADDR (32'h0000_0FF0),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_MemWrite    (i_MemWrite),
    .i_mem_addr    (i_mem_addr),
    .i_mem_wdata   (i_mem_wdata),
    .o_full        (o_full),
    .o_ram_valid   (o_ram_valid),
    .i_ram_ready   (i_ram_ready),
    .o_ram_addr    (o_ram_addr),
    .o_ram_wdata   (o_ram_wdata),
    .o_done        (o_done),
    .o_done_code   (o_done_code),
    .o_misaligned  (o_misaligned),
    .o_overflow    (o_overflow),
    .o_store_count (o_store_count)
  );

  store_entry_t     exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               n_drained = 0;
  logic             exp_done, exp_mis, exp_ovf;
  logic [31:0]      exp_code;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_done = 1'b0;
    exp_mis  = 1'b0;
    exp_ovf  = 1'b0;
    exp_code = '0;
    exp_cnt  = '0;
  endtask

  // RAM side: handshake sampled mid-cycle, pop happens at the following edge.
  always @(negedge clk) begin
    if (reset_n && o_ram_valid && i_ram_ready) begin
      check_eq("pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check_eq("ram_addr", o_ram_addr, exp_q[0].addr);
        check_eq("ram_wdata", o_ram_wdata, exp_q[0].wdata);
        void'(exp_q.pop_front());
        n_drained++;
      end
    end
  end

  // Drive one cycle of the store port; model the classification at drive time.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    i_MemWrite  = we;
    i_mem_addr  = a;
    i_mem_wdata = d;
    if (we && !exp_done) begin
      if (a[1:0] != 2'b00) exp_mis = 1'b1;
      else if (a == 32'h0000_0FF0) begin
        exp_done = 1'b1;
        exp_code = d;
      end else if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
      else begin
        exp_q.push_back('{addr: a, wdata: d});
`ifdef STORE_SINK_COUNT_EN
        if (exp_cnt != '1) exp_cnt = exp_cnt + CNT_W'(1);
`endif
      end
    end
    @(posedge clk);
    #1;
    i_MemWrite = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".done"}, 32'(o_done), 32'(exp_done));
    check_eq({tag, ".code"}, o_done_code, exp_code);
    check_eq({tag, ".mis"}, 32'(o_misaligned), 32'(exp_mis));
    check_eq({tag, ".ovf"}, 32'(o_overflow), 32'(exp_ovf));
    check_eq({tag, ".cnt"}, 32'(o_store_count), 32'(exp_cnt));
    check_eq({tag, ".full"}, 32'(o_full), 32'(exp_q.size() == DEPTH));
    check_eq({tag, ".valid"}, 32'(o_ram_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() > 0) begin
      check_eq({tag, ".head_addr"}, o_ram_addr, exp_q[0].addr);
      check_eq({tag, ".head_data"}, o_ram_wdata, exp_q[0].wdata);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".full"}, 32'(o_full), 32'd0);
    check_eq({tag, ".valid"}, 32'(o_ram_valid), 32'd0);
    check_eq({tag, ".addr"}, o_ram_addr, 32'd0);
    check_eq({tag, ".wdata"}, o_ram_wdata, 32'd0);
    check_eq({tag, ".done"}, 32'(o_done), 32'd0);
    check_eq({tag, ".code"}, o_done_code, 32'd0);
    check_eq({tag, ".mis"}, 32'(o_misaligned), 32'd0);
    check_eq({tag, ".ovf"}, 32'(o_overflow), 32'd0);
    check_eq({tag, ".cnt"}, 32'(o_store_count), 32'd0);
  endtask

  // Bounded drain: raise ready until the model and DUT are both empty.
  task automatic drain(input string tag);
    i_ram_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !o_ram_valid) break;
      @(posedge clk);
      #1;
    end
    check_eq({tag, ".drained_valid"}, 32'(o_ram_valid), 32'd0);
    check_eq({tag, ".drained_model"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n     = 1'b0;
    i_MemWrite  = 1'b0;
    i_mem_addr  = '0;
    i_mem_wdata = '0;
    i_ram_ready = 1'b0;
    reset_model();
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst");

    // Two stores drained in order.
    i_ram_ready = 1'b1;
    n_drained   = 0;
    step(1'b1, 32'h10, 32'd5);
    step(1'b1, 32'h14, 32'd7);
    step(1'b0, 32'h0, 32'h0);
    drain("two");
    check_eq("two.n_drained", 32'(n_drained), 32'd2);
    check_state("two");

    // Five back-to-back stores with the RAM stalled.
    i_ram_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h40 + 32'(i * 4), 32'hA0 + 32'(i));
      check_state($sformatf("fill%0d", i));
    end
    step(1'b0, 32'h0, 32'h0);
    check_state("stall");
    n_drained = 0;
    drain("ovf");
    check_eq("ovf.n_drained", 32'(n_drained), 32'd4);
    check_state("ovf");

    // Misaligned store.
    step(1'b1, 32'h22, 32'hDEAD);
    check_state("mis");

    // TOHOST with two entries pending.
    i_ram_ready = 1'b0;
    step(1'b1, 32'h50, 32'd1);
    step(1'b1, 32'h54, 32'd2);
    step(1'b1, 32'h0000_0FF0, 32'd100);
    check_state("tohost");
    step(1'b1, 32'h30, 32'd9);
    check_state("after_done");
    n_drained = 0;
    drain("done");
    check_eq("done.n_drained", 32'(n_drained), 32'd2);
    check_state("done");

    // Leave DONE via reset, fill three entries, then reset mid-cycle.
    reset_n = 1'b0;
    reset_model();
    #2;
    check_reset_outputs("rst2");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    i_ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80 + 32'(i * 4), 32'h300 + 32'(i));
    check_state("prefill");
    #2;
    reset_n = 1'b0;
    reset_model();
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("after_mid_rst");
    step(1'b0, 32'h0, 32'h0);
    check_eq("after_mid_rst.valid2", 32'(o_ram_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_store_sink.md
# mem_store_sink

Receiver for the pipeline's write-back store port (`MemWrite` / address / write data). Accepts store strobes from the datapath, buffers them in a small FIFO, drains them to the data RAM over a valid/ready handshake, and decodes a memory-mapped TOHOST address. A TOHOST write ends the test, letting a run finish in hardware instead of through a bench-side register check.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TOHOST_ADDR`, 32'h0000_0FF0: byte address decoded as the end-of-test mailbox.
- `CNT_W`, 16: width of the store counter.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `i_MemWrite`  in  1  store strobe from the WB store port.
- `i_mem_addr`  in  32  store byte address.
- `i_mem_wdata`  in  32  store data.
- `o_full`  out  1  FIFO full; the datapath stalls stores while high.
- `o_ram_valid`  out  1  head entry available for the RAM.
- `i_ram_ready`  in  1  RAM accepts the head entry.
- `o_ram_addr`  out  32  head byte address.
- `o_ram_wdata`  out  32  head data.
- `o_done`  out  1  TOHOST written; sticky.
- `o_done_code`  out  32  data of the TOHOST write.
- `o_misaligned`  out  1  sticky; a store with `addr[1:0]` ≠ 0 was seen.
- `o_overflow`  out  1  sticky; a store arrived while `o_full`.
- `o_store_count`  out  CNT_W  number of enqueued stores; saturating.

## Operation
- FSM states: RUN, DONE. Reset enters RUN.
- Each cycle with `i_MemWrite`=1 in RUN, the store is classified in this priority order:
  - Misaligned (`addr[1:0]` ≠ 0): dropped; `o_misaligned` set.
  - `addr == TOHOST_ADDR`: not enqueued; `o_done_code` ← wdata; `o_done` ← 1; FSM → DONE.
  - `o_full`=1: dropped; `o_overflow` set. A same-cycle pop does not free the slot.
  - Otherwise: {addr, wdata} pushed; `o_store_count` increments and saturates at all-ones.
- In DONE, all incoming stores are ignored, with no flag or count change. The FIFO keeps draining. Only reset leaves DONE.
- Drain side:
  - `o_ram_valid` = FIFO not empty; `o_ram_addr` and `o_ram_wdata` = head entry.
  - Pop happens on `o_ram_valid && i_ram_ready`.
  - Head outputs stay stable while valid and not ready.
- Pointers are log2(DEPTH)+1 bits with wrap bit. Full when indices are equal and wrap bits differ; empty when both are equal.
- Push and pop in the same cycle (not full, not empty) leave occupancy unchanged.

## Timing
- Reset values: `o_full`=0, `o_ram_valid`=0, `o_ram_addr`=0, `o_ram_wdata`=0, `o_done`=0, `o_done_code`=0, `o_misaligned`=0, `o_overflow`=0, `o_store_count`=0; FIFO empty.
- All outputs are registered or derived only from registered state; no combinational path from `i_*` to any output.
- Push latency: a store accepted at edge N gives `o_ram_valid`=1 after edge N.
- `o_done` rises after the TOHOST edge. It does not wait for the FIFO to drain; the drain is complete when `o_done && !o_ram_valid`.
- `o_full` updates after the edge that fills the FIFO and after the edge that pops from full.
- Reset asserted mid-operation discards all FIFO contents immediately (asynchronous).

## Configuration
- Macro: `STORE_SINK_COUNT_EN`.
- Defined: `o_store_count` is implemented as specified.
- Undefined: no counter register; `o_store_count` is tied to 0.

## Structure
- Package `store_sink_pkg`:
  - state enum `sink_state_t` {RUN, DONE};
  - `TOHOST_ADDR_DEFAULT`;
  - struct `store_entry_t` {addr[31:0], wdata[31:0]}.
- Sub-module `store_fifo`, parameterized by DEPTH with `store_entry_t` payload, provides:
  - push, pop, full, empty, and head.
- The top level holds the classifier, FSM, sticky flags and counter.

## Test plan
- Two stores, addr 0x10/data 5 and addr 0x14/data 7, with `i_ram_ready`=1 → RAM sees (0x10,5) then (0x14,7) in order; `o_store_count`=2.
- `i_ram_ready`=0 with five back-to-back aligned stores (DEPTH=4):
  - `o_full`=1 after the 4th;
  - 5th store dropped, `o_overflow`=1, `o_store_count`=4;
  - raising ready drains exactly 4 entries.
- Store to addr 0x22 → not enqueued; `o_misaligned`=1; count unchanged.
- Store data 100 to 0xFF0 while 2 entries are pending:
  - `o_done`=1 and `o_done_code`=100 the next cycle;
  - pending entries still drain;
  - a later store to 0x30 is ignored.
- Fill 3 entries, assert `reset_n`=0 mid-cycle → all outputs return to reset values immediately; after release `o_ram_valid` stays 0.
- Build without `STORE_SINK_COUNT_EN`, 3 stores → `o_store_count` stays 0; data path unchanged.
